wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writers:
  - the pipeline writeback stage (`pipe_*`);
  - the multi-cycle mul/div unit (`mdu_*`).
- Keeps a 32-entry pending-write scoreboard so decode can stall on operands the MDU has not yet written.
- Sits between the WB stage / MDU and the regfile write port (`wen`/`waddr`/`win`), and feeds busy flags to the hazard unit.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/wb_scoreboard.sv | 37 +++
 rtl/wb_port_arbiter.sv | 106 ++++++++++
 tb/tb_wb_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the register-file write-port slice.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int REG_ZERO = 0;

  // Register numbers used by benches.
  localparam int REG_T0 = 8;
  localparam int REG_S0 = 16;
  localparam int REG_T8 = 24;

  // Which writer owns the regfile port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MDU  = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register with an MDU result in flight.
module wb_scoreboard #(
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic                   busy1,
  output logic                   busy2,
  output logic [(1<<ADDR_W)-1:0] pending
);

  logic [(1<<ADDR_W)-1:0] pending_nxt;

  // Next pending vector: clear first so a same-cycle set overrides it.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clock) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign busy1 = pending[raddr1];
  assign busy2 = pending[raddr2];

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the regfile write port between WB stage and MDU, with
// starvation control and a pending-write scoreboard for decode.
module wb_port_arbiter #(
  parameter int DATA_W       = mips_pkg::DATA_W,
  parameter int ADDR_W       = mips_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pipe_wen,
  input  logic [ADDR_W-1:0]      pipe_waddr,
  input  logic [DATA_W-1:0]      pipe_wdata,
  input  logic                   mdu_valid,
  input  logic [ADDR_W-1:0]      mdu_waddr,
  input  logic [DATA_W-1:0]      mdu_wdata,
  output logic                   mdu_ready,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_waddr,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   pipe_hold,
  output logic                   rf_wen,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [(1<<ADDR_W)-1:0] pending
);

  import mips_pkg::*;

  grant_e            grant;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              mdu_hs;
  logic              mdu_wait;
  logic [3:0]        starve_cnt;
  logic              mdu_wr_q;

  assign mdu_ready = reset & (~pipe_wen | pipe_hold);
  assign mdu_hs    = (grant == GNT_MDU);
  assign mdu_wait  = mdu_valid & ~mdu_ready;

  // Grant selection: WB first unless held, then the MDU.
  always_comb begin
    grant    = GNT_NONE;
    gnt_addr = pipe_waddr;
    gnt_data = pipe_wdata;
    if (pipe_wen && !pipe_hold) begin
      grant = GNT_PIPE;
    end else if (mdu_valid && mdu_ready) begin
      grant    = GNT_MDU;
      gnt_addr = mdu_waddr;
      gnt_data = mdu_wdata;
    end
  end

  // Registered write port; a grant to register 0 is consumed without a write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mdu_wr_q <= 1'b0;
    end else begin
      rf_wen   <= 1'b0;
      mdu_wr_q <= mdu_hs;
      if (grant != GNT_NONE) begin
        rf_wen   <= (gnt_addr != ADDR_W'(REG_ZERO));
        rf_waddr <= gnt_addr;
        rf_wdata <= gnt_data;
      end
    end
  end

  // Starve counter and one-cycle pipe hold once the MDU has waited long enough.
  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_cnt <= '0;
      pipe_hold  <= 1'b0;
    end else begin
      if (mdu_hs || !mdu_valid) starve_cnt <= '0;
      else if (mdu_wait)        starve_cnt <= starve_cnt + 4'd1;
      pipe_hold <= mdu_wait && (starve_cnt == 4'(STARVE_LIMIT - 1));
    end
  end

  // The pending bit clears one cycle after the MDU result reaches rf_*, so
  // decode never sees busy low before the regfile has captured the data.
  wb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (issue_valid),
    .set_addr (issue_waddr),
    .clr_en   (mdu_wr_q),
    .clr_addr (rf_waddr),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .busy1    (busy1),
    .busy2    (busy2),
    .pending  (pending)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus multi-cycle sequences.
module tb_wb_port_arbiter;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_wen;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        busy1;
  logic        busy2;
  logic        pipe_hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clock = ~clock;

  wb_port_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .STARVE_LIMIT (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pipe_wen    (pipe_wen),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .mdu_valid   (mdu_valid),
    .mdu_waddr   (mdu_waddr),
    .mdu_wdata   (mdu_wdata),
    .mdu_ready   (mdu_ready),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .busy1       (busy1),
    .busy2       (busy2),
    .pipe_hold   (pipe_hold),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pending     (pending)
  );

  typedef struct {
    logic        rst;
    logic        pwen;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        rdy;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hold;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic rst, input logic pwen, input logic [4:0] pa,
                              input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                              input logic [31:0] md, input logic rdy, input logic wen,
                              input logic [4:0] wa, input logic [31:0] wd, input logic hold);
    vec_t v;
    v.rst = rst; v.pwen = pwen; v.pa = pa; v.pd = pd;
    v.mv = mv; v.ma = ma; v.md = md;
    v.rdy = rdy; v.wen = wen; v.wa = wa; v.wd = wd; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset       = 1'b1;
    pipe_wen    = 1'b0;
    pipe_waddr  = '0;
    pipe_wdata  = '0;
    mdu_valid   = 1'b0;
    mdu_waddr   = '0;
    mdu_wdata   = '0;
    issue_valid = 1'b0;
    issue_waddr = '0;
    raddr1      = '0;
    raddr2      = '0;
  endtask

  // Move to the middle of the next cycle's drive window.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    // Table: rst pwen pa pd mv ma md | rdy wen wa wd hold
    vt[0]  = mk(0, 1, 5'd8,  32'h1234, 1, 5'd16, 32'hCAFE, 0, 0, 5'd0,  32'h0,    0);
    vt[1]  = mk(0, 1, 5'd8,  32'h1234, 1, 5'd16, 32'hCAFE, 0, 0, 5'd0,  32'h0,    0);
    vt[2]  = mk(1, 1, 5'd8,  32'h1234, 0, 5'd0,  32'h0,    0, 0, 5'd0,  32'h0,    0);
    vt[3]  = mk(1, 1, 5'd9,  32'h9999, 1, 5'd16, 32'hCAFE, 0, 1, 5'd8,  32'h1234, 0);
    vt[4]  = mk(1, 0, 5'd0,  32'h0,    1, 5'd16, 32'hCAFE, 1, 1, 5'd9,  32'h9999, 0);
    vt[5]  = mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 1, 5'd16, 32'hCAFE, 0);
    vt[6]  = mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 0, 5'd16, 32'hCAFE, 0);
    vt[7]  = mk(1, 1, 5'd10, 32'hA0A0, 1, 5'd24, 32'h2424, 0, 0, 5'd16, 32'hCAFE, 0);
    vt[8]  = mk(1, 1, 5'd10, 32'hA0A0, 1, 5'd24, 32'h2424, 0, 1, 5'd10, 32'hA0A0, 0);
    vt[9]  = mk(1, 1, 5'd10, 32'hA0A0, 1, 5'd24, 32'h2424, 0, 1, 5'd10, 32'hA0A0, 0);
    vt[10] = mk(1, 1, 5'd10, 32'hA0A0, 1, 5'd24, 32'h2424, 0, 1, 5'd10, 32'hA0A0, 0);
    vt[11] = mk(1, 1, 5'd10, 32'hA0A0, 1, 5'd24, 32'h2424, 1, 1, 5'd10, 32'hA0A0, 1);
    vt[12] = mk(1, 1, 5'd10, 32'hA0A0, 0, 5'd0,  32'h0,    0, 1, 5'd24, 32'h2424, 0);
    vt[13] = mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 1, 5'd10, 32'hA0A0, 0);
    vt[14] = mk(1, 0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    1, 0, 5'd10, 32'hA0A0, 0);

    for (int i = 0; i < 15; i++) begin
      reset      = vt[i].rst;
      pipe_wen   = vt[i].pwen;
      pipe_waddr = vt[i].pa;
      pipe_wdata = vt[i].pd;
      mdu_valid  = vt[i].mv;
      mdu_waddr  = vt[i].ma;
      mdu_wdata  = vt[i].md;
      @(negedge clock);
      chk($sformatf("v%0d mdu_ready", i), 32'(mdu_ready), 32'(vt[i].rdy));
      chk($sformatf("v%0d rf_wen", i),    32'(rf_wen),    32'(vt[i].wen));
      chk($sformatf("v%0d rf_waddr", i),  32'(rf_waddr),  32'(vt[i].wa));
      chk($sformatf("v%0d rf_wdata", i),  rf_wdata,       vt[i].wd);
      chk($sformatf("v%0d pipe_hold", i), 32'(pipe_hold), 32'(vt[i].hold));
      chk($sformatf("v%0d pending", i),   pending,        32'h0);
      next();
    end

    // Scoreboard: issue to 17, result accepted in cycle 5, busy low from cycle 7.
    idle();
    issue_valid = 1'b1; issue_waddr = 5'd17; raddr1 = 5'd17; raddr2 = 5'd5;
    @(negedge clock); chk("sb c0 busy1", 32'(busy1), 32'd0);
    next();
    issue_valid = 1'b0;
    @(negedge clock);
    chk("sb c1 busy1", 32'(busy1), 32'd1);
    chk("sb c1 busy2", 32'(busy2), 32'd0);
    chk("sb c1 pending", pending, 32'h0002_0000);
    for (int c = 2; c < 5; c++) begin
      next();
      @(negedge clock); chk($sformatf("sb c%0d busy1", c), 32'(busy1), 32'd1);
    end
    next();
    mdu_valid = 1'b1; mdu_waddr = 5'd17; mdu_wdata = 32'h1111;
    @(negedge clock);
    chk("sb c5 mdu_ready", 32'(mdu_ready), 32'd1);
    chk("sb c5 busy1", 32'(busy1), 32'd1);
    next();
    mdu_valid = 1'b0; raddr2 = 5'd17;
    @(negedge clock);
    chk("sb c6 rf_wen", 32'(rf_wen), 32'd1);
    chk("sb c6 rf_waddr", 32'(rf_waddr), 32'd17);
    chk("sb c6 rf_wdata", rf_wdata, 32'h1111);
    chk("sb c6 busy1", 32'(busy1), 32'd1);
    chk("sb c6 busy2", 32'(busy2), 32'd1);
    next();
    @(negedge clock);
    chk("sb c7 busy1", 32'(busy1), 32'd0);
    chk("sb c7 pending", pending, 32'h0);
    next();

    // Collision on 18: set beats clear; a pipe write leaves the bit alone.
    idle();
    issue_valid = 1'b1; issue_waddr = 5'd18;
    next();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_waddr = 5'd18; mdu_wdata = 32'h1818;
    @(negedge clock);
    chk("col c1 mdu_ready", 32'(mdu_ready), 32'd1);
    chk("col c1 pending", pending, 32'h0004_0000);
    next();
    mdu_valid = 1'b0;
    issue_valid = 1'b1; issue_waddr = 5'd18;
    @(negedge clock);
    chk("col c2 rf_wen", 32'(rf_wen), 32'd1);
    chk("col c2 rf_waddr", 32'(rf_waddr), 32'd18);
    chk("col c2 rf_wdata", rf_wdata, 32'h1818);
    next();
    issue_valid = 1'b0;
    pipe_wen = 1'b1; pipe_waddr = 5'd18; pipe_wdata = 32'hBEEF;
    @(negedge clock); chk("col c3 pending set wins", pending, 32'h0004_0000);
    next();
    pipe_wen = 1'b0;
    @(negedge clock);
    chk("col c4 rf_wdata", rf_wdata, 32'hBEEF);
    chk("col c4 pending", pending, 32'h0004_0000);
    next();
    mdu_valid = 1'b1; mdu_waddr = 5'd18; mdu_wdata = 32'h0002;
    @(negedge clock); chk("col c5 pending after pipe", pending, 32'h0004_0000);
    next();
    mdu_valid = 1'b0;
    @(negedge clock); chk("col c6 rf_waddr", 32'(rf_waddr), 32'd18);
    next();
    @(negedge clock); chk("col c7 pending", pending, 32'h0);
    next();

    // MDU grant to register 0 and an issue to register 0.
    idle();
    mdu_valid = 1'b1; mdu_waddr = 5'd0; mdu_wdata = 32'hDEAD;
    issue_valid = 1'b1; issue_waddr = 5'd0;
    @(negedge clock); chk("r0 mdu_ready", 32'(mdu_ready), 32'd1);
    next();
    idle();
    @(negedge clock);
    chk("r0 rf_wen", 32'(rf_wen), 32'd0);
    chk("r0 pending", pending, 32'h0);
    next();

    // Hold with mdu_valid dropped: still one cycle, and no write follows.
    idle();
    pipe_wen = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
    mdu_valid = 1'b1; mdu_waddr = 5'd5; mdu_wdata = 32'h55;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); chk($sformatf("drop c%0d pipe_hold", c), 32'(pipe_hold), 32'd0);
      next();
    end
    mdu_valid = 1'b0;
    @(negedge clock);
    chk("drop c4 pipe_hold", 32'(pipe_hold), 32'd1);
    chk("drop c4 mdu_ready", 32'(mdu_ready), 32'd1);
    chk("drop c4 rf_waddr", 32'(rf_waddr), 32'd3);
    next();
    pipe_wen = 1'b0;
    @(negedge clock);
    chk("drop c5 rf_wen", 32'(rf_wen), 32'd0);
    chk("drop c5 pipe_hold", 32'(pipe_hold), 32'd0);
    next();

    // Mid-operation reset drops pending state and the waiting result.
    idle();
    issue_valid = 1'b1; issue_waddr = 5'd20;
    next();
    issue_valid = 1'b0;
    pipe_wen = 1'b1; pipe_waddr = 5'd8; pipe_wdata = 32'h8;
    mdu_valid = 1'b1; mdu_waddr = 5'd20; mdu_wdata = 32'h20;
    next();
    reset = 1'b0;
    @(negedge clock);
    chk("mrst mdu_ready", 32'(mdu_ready), 32'd0);
    chk("mrst pending before edge", pending, 32'h0010_0000);
    next();
    idle();
    @(negedge clock);
    chk("mrst pending", pending, 32'h0);
    chk("mrst rf_wen", 32'(rf_wen), 32'd0);
    chk("mrst pipe_hold", 32'(pipe_hold), 32'd0);
    chk("mrst mdu_ready after", 32'(mdu_ready), 32'd1);
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
